// File: rtl/stage3_branch_unit.sv
// Execute-stage branch resolution with a saturating-counter direction table.
// Optional BRANCH_STATS_EN adds branch / mispredict event counters.
module stage3_branch_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CTR_BITS    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            valid,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [3:0]      branch_type,
  input  logic [3:0]      compare,
  input  logic            predicted_taken,
  input  logic [XLEN-1:0] s3_instruction_addr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] s1_lookup_addr,
  output logic            s1_predict_taken,
  output logic            do_flush,
  output logic [XLEN-1:0] redirect_addr,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic [XLEN-1:0] link_addr
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] ctr_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [BHT_ENTRIES];
  logic                do_flush_q, do_flush_d;
  logic [XLEN-1:0]     redirect_q, redirect_d;
  logic                pred_q, pred_d;

  logic                live, taken, train;
  logic [XLEN-1:0]     pc_plus4, pc_imm;
  logic [IDX_W-1:0]    upd_idx, lookup_idx;
  logic [CTR_BITS-1:0] upd_ctr;
  logic                br_resolved, bj_mispredict;

  assign live       = valid & ~stall & ~do_flush_q;
  assign taken      = |(branch_type & compare);
  assign pc_plus4   = s3_instruction_addr + XLEN'(4);
  assign pc_imm     = s3_instruction_addr + imm;
  assign link_addr  = pc_plus4;
  assign upd_idx    = s3_instruction_addr[IDX_W+1:2];
  assign lookup_idx = s1_lookup_addr[IDX_W+1:2];
  assign upd_ctr    = ctr_q[upd_idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s1_lookup_addr[XLEN-1:IDX_W+2], s1_lookup_addr[1:0],
                              jalr_target[0]};

  // Resolution priority JALR > JAL > branch; only the branch arm trains.
  always_comb begin
    do_flush_d    = 1'b0;
    redirect_d    = redirect_q;
    train         = 1'b0;
    br_resolved   = 1'b0;
    bj_mispredict = 1'b0;
    if (stall) begin
      do_flush_d = do_flush_q;
    end else if (live) begin
      if (is_jalr) begin
        do_flush_d = 1'b1;
        redirect_d = {jalr_target[XLEN-1:1], 1'b0};
      end else if (is_jal) begin
        if (!predicted_taken) begin
          do_flush_d    = 1'b1;
          bj_mispredict = 1'b1;
          redirect_d    = pc_imm;
        end
      end else if (is_branch) begin
        train       = 1'b1;
        br_resolved = 1'b1;
        if (taken != predicted_taken) begin
          do_flush_d    = 1'b1;
          bj_mispredict = 1'b1;
          redirect_d    = taken ? pc_imm : pc_plus4;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (train) begin
      if (taken && upd_ctr != CTR_MAX) begin
        ctr_d[upd_idx] = upd_ctr + CTR_BITS'(1);
      end else if (!taken && upd_ctr != '0) begin
        ctr_d[upd_idx] = upd_ctr - CTR_BITS'(1);
      end
    end
  end

  // Lookup reads the pre-update table, so a same-index train shows old data.
  assign pred_d = stall ? pred_q : ctr_q[lookup_idx][CTR_BITS-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= CTR_RST;
      end
      do_flush_q <= 1'b0;
      redirect_q <= '0;
      pred_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
      do_flush_q <= do_flush_d;
      redirect_q <= redirect_d;
      pred_q     <= pred_d;
    end
  end

  assign do_flush         = do_flush_q;
  assign redirect_addr    = redirect_q;
  assign s1_predict_taken = pred_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (br_resolved && stat_br_q != '1) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (bj_mispredict && stat_mp_q != '1) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`else
  logic unused_stats;
  assign unused_stats = br_resolved ^ bj_mispredict;
`endif

endmodule

// File: tb/tb_stage3_branch_unit.sv
// Directed-vector bench for stage3_branch_unit with hand-computed expectations.
module tb_stage3_branch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, valid, is_branch, is_jal, is_jalr, predicted_taken;
  logic [3:0]  branch_type, compare;
  logic [31:0] s3_instruction_addr, imm, jalr_target, s1_lookup_addr;
  logic        s1_predict_taken, do_flush;
  logic [31:0] redirect_addr, link_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stage3_branch_unit #(.XLEN(32), .BHT_ENTRIES(64), .CTR_BITS(2)) dut (
    .clock               (clock),
    .reset               (reset),
    .stall               (stall),
    .valid               (valid),
    .is_branch           (is_branch),
    .is_jal              (is_jal),
    .is_jalr             (is_jalr),
    .branch_type         (branch_type),
    .compare             (compare),
    .predicted_taken     (predicted_taken),
    .s3_instruction_addr (s3_instruction_addr),
    .imm                 (imm),
    .jalr_target         (jalr_target),
    .s1_lookup_addr      (s1_lookup_addr),
    .s1_predict_taken    (s1_predict_taken),
    .do_flush            (do_flush),
    .redirect_addr       (redirect_addr),
`ifdef BRANCH_STATS_EN
    .stat_branches       (stat_branches),
    .stat_mispredicts    (stat_mispredicts),
`endif
    .link_addr           (link_addr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    valid     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] off,
                          input logic [3:0] bt, input logic [3:0] cmp, input logic pt);
    idle();
    valid               = 1'b1;
    is_branch           = 1'b1;
    s3_instruction_addr = pc;
    imm                 = off;
    branch_type         = bt;
    compare             = cmp;
    predicted_taken     = pt;
  endtask

  task automatic drive_jal(input logic [31:0] pc, input logic [31:0] off, input logic pt);
    idle();
    valid               = 1'b1;
    is_jal              = 1'b1;
    s3_instruction_addr = pc;
    imm                 = off;
    predicted_taken     = pt;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    idle();
    branch_type = '0; compare = '0; predicted_taken = 1'b0;
    s3_instruction_addr = '0; imm = '0; jalr_target = '0; s1_lookup_addr = '0;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_flush", 32'(do_flush), 32'd0);
    check_eq("rst_redirect", redirect_addr, 32'h0);
    check_eq("rst_pred", 32'(s1_predict_taken), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    s1_lookup_addr = 32'h100;
    tick();
    check_eq("lookup_init", 32'(s1_predict_taken), 32'd0);

    // BEQ taken, predicted not-taken; table index 0: 1 -> 2
    drive_br(32'h100, 32'h40, 4'b0001, 4'b0001, 1'b0);
    #1 check_eq("beq_link", link_addr, 32'h104);
    tick(); idle();
    check_eq("beq_flush", 32'(do_flush), 32'd1);
    check_eq("beq_redirect", redirect_addr, 32'h140);
    tick();
    check_eq("beq_pulse_end", 32'(do_flush), 32'd0);
    check_eq("beq_redirect_hold", redirect_addr, 32'h140);

    // BNE not taken, predicted taken; index 0: 2 -> 1
    drive_br(32'h200, 32'h0, 4'b0010, 4'b0001, 1'b1);
    tick(); idle();
    check_eq("bne_flush", 32'(do_flush), 32'd1);
    check_eq("bne_redirect", redirect_addr, 32'h204);
    s1_lookup_addr = 32'h300;
    tick();
    check_eq("bne_pulse_end", 32'(do_flush), 32'd0);

    // Four taken at 0x300 (index 0): 1 -> 2 -> 3 -> 3 -> 3
    drive_br(32'h300, 32'h0, 4'b0001, 4'b0001, 1'b1);
    tick();
    check_eq("old_data_pred", 32'(s1_predict_taken), 32'd0);
    check_eq("taken_ok_noflush", 32'(do_flush), 32'd0);
    repeat (3) begin
      drive_br(32'h300, 32'h0, 4'b0001, 4'b0001, 1'b1);
      tick();
    end
    idle(); tick();
    check_eq("sat_hi_pred", 32'(s1_predict_taken), 32'd1);

    // Four not-taken: 3 -> 2 -> 1 -> 0 -> 0, then two taken: 0 -> 1 -> 2
    repeat (4) begin
      drive_br(32'h300, 32'h0, 4'b0001, 4'b0010, 1'b0);
      tick();
    end
    idle(); tick();
    check_eq("sat_lo_pred", 32'(s1_predict_taken), 32'd0);
    check_eq("sat_lo_noflush", 32'(do_flush), 32'd0);
    repeat (2) begin
      drive_br(32'h300, 32'h0, 4'b0001, 4'b0001, 1'b1);
      tick();
    end
    idle(); tick();
    check_eq("no_underflow_pred", 32'(s1_predict_taken), 32'd1);

    // JALR, then a mispredicting not-taken branch in the shadow cycle
    idle();
    valid = 1'b1; is_jalr = 1'b1;
    s3_instruction_addr = 32'h400; jalr_target = 32'h1235;
    #1 check_eq("jalr_link", link_addr, 32'h404);
    tick();
    check_eq("jalr_flush", 32'(do_flush), 32'd1);
    check_eq("jalr_redirect", redirect_addr, 32'h1234);
    drive_br(32'h500, 32'h0, 4'b0001, 4'b0010, 1'b1);
    tick(); idle();
    check_eq("shadow_flush", 32'(do_flush), 32'd0);
    check_eq("shadow_redirect", redirect_addr, 32'h1234);
    tick();
    check_eq("shadow_no_train", 32'(s1_predict_taken), 32'd1);

    // JAL with negative offset, mispredicted; then correctly predicted JAL
    drive_jal(32'h600, 32'hFFFF_FFF0, 1'b0);
    tick(); idle();
    check_eq("jal_flush", 32'(do_flush), 32'd1);
    check_eq("jal_redirect", redirect_addr, 32'h5F0);
    tick();
    check_eq("jal_pulse_end", 32'(do_flush), 32'd0);
    drive_jal(32'h700, 32'h80, 1'b1);
    tick(); idle();
    check_eq("jal_pred_ok", 32'(do_flush), 32'd0);
    check_eq("jal_pred_ok_hold", redirect_addr, 32'h5F0);

    // Address wrap: branch at top of memory (index 63: 1 -> 2)
    drive_br(32'hFFFF_FFFC, 32'h8, 4'b0001, 4'b0001, 1'b0);
    #1 check_eq("wrap_link", link_addr, 32'h0);
    tick(); idle();
    check_eq("wrap_flush", 32'(do_flush), 32'd1);
    check_eq("wrap_redirect", redirect_addr, 32'h4);
    s1_lookup_addr = 32'h100;
    tick();
    check_eq("pre_stall_pred", 32'(s1_predict_taken), 32'd1);

    // Stall with a mispredicting branch at index 0 (counter 2)
    s1_lookup_addr = 32'h14;
    stall = 1'b1;
    drive_br(32'h100, 32'h0, 4'b0001, 4'b0010, 1'b1);
    repeat (2) begin
      tick();
      check_eq("stall_flush", 32'(do_flush), 32'd0);
      check_eq("stall_redirect", redirect_addr, 32'h4);
      check_eq("stall_pred_hold", 32'(s1_predict_taken), 32'd1);
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_flush", 32'(do_flush), 32'd1);
    check_eq("unstall_redirect", redirect_addr, 32'h104);
    check_eq("unstall_lookup", 32'(s1_predict_taken), 32'd0);
    idle();
    s1_lookup_addr = 32'h100;
    tick();
    check_eq("unstall_pulse_end", 32'(do_flush), 32'd0);
    check_eq("unstall_train", 32'(s1_predict_taken), 32'd0);

    // Asynchronous reset while a flush is being presented
    drive_br(32'h100, 32'h40, 4'b0001, 4'b0001, 1'b0);
    s1_lookup_addr = 32'hFFFF_FFFC;
    tick(); idle();
    check_eq("pre_reset_flush", 32'(do_flush), 32'd1);
    check_eq("pre_reset_pred", 32'(s1_predict_taken), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_flush", 32'(do_flush), 32'd0);
    check_eq("async_redirect", redirect_addr, 32'h0);
    check_eq("async_pred", 32'(s1_predict_taken), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_eq("ctr_reset_pred", 32'(s1_predict_taken), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
